// File: rtl/restador_secuencial_if.sv
// ============================================================================
// Module   : restador_secuencial_if
// Purpose  : Signal bundle for restador_secuencial. Groups the upstream
//            operation handshake, the adder operand/result bus and the
//            downstream result handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   in_valid, in_ready, A, B, op     : operation request handshake
//   add_a, add_b, add_sum, add_cout  : link to the external ripple adder
//   out_valid, out_ready             : result handshake
//   Res, C, Ovf, Zero                : registered result and flags
// Modports
//   slave  : the sequencer's view (restador_secuencial)
//   master : the surrounding environment (producer, adder, consumer)
// ============================================================================
`default_nettype none

interface restador_secuencial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             op;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Res;
  logic             C;
  logic             Ovf;
  logic             Zero;

  modport slave (
    input  in_valid, A, B, op, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, Res, C, Ovf, Zero
  );

  modport master (
    output in_valid, A, B, op, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, Res, C, Ovf, Zero
  );
endinterface

`default_nettype wire

// File: rtl/restador_secuencial.sv
// ============================================================================
// Module   : restador_secuencial
// Purpose  : Sequencing stage in front of a carry-in-less ripple adder.
//            Add is one adder pass; subtract is two passes:
//              pass 1: T = A + ~B   (carry c1)
//              pass 2: R = T + 1    (final carry = c1 | pass-2 carry)
//            Result and flags are registered and offered through a
//            valid/ready handshake. One operation in flight at a time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : restador_secuencial_if.slave
//            in_valid/in_ready/A/B/op  - operation request (op 1 = subtract)
//            add_a/add_b               - operands driven to the adder
//            add_sum/add_cout          - adder result (combinational)
//            out_valid/out_ready       - result handshake
//            Res/C/Ovf/Zero            - result, unsigned carry (no-borrow on
//                                        subtract), signed overflow, zero
// Configuration
//   RESTADOR_SAT_EN : when defined, Res saturates unsigned (add carry -> all
//                     ones, subtract borrow -> 0). C and Ovf keep the
//                     unsaturated meaning; Zero follows the saturated Res.
// ============================================================================
`default_nettype none

module restador_secuencial #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  restador_secuencial_if.slave bus
);

  localparam int C_MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_t;
  logic             r_c1;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_sub_c;
  logic [WIDTH-1:0] w_add_res;
  logic [WIDTH-1:0] w_sub_res;

  // Adder operands are decoded only from registered state, so nothing on
  // the request side can ripple through to the adder.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_PASS1: begin
        w_add_a = r_a;
        w_add_b = r_op ? ~r_b : r_b;
      end
      S_PASS2: begin
        w_add_a = r_t;
        w_add_b = WIDTH'(1);
      end
      default: begin
        w_add_a = '0;
        w_add_b = '0;
      end
    endcase
  end

  // Flags. Ovf is evaluated against the unsaturated adder output, which is
  // the true modulo result on the cycle the result is loaded.
  assign w_add_ovf = (r_a[C_MSB] == r_b[C_MSB]) && (bus.add_sum[C_MSB] != r_a[C_MSB]);
  assign w_sub_ovf = (r_a[C_MSB] != r_b[C_MSB]) && (bus.add_sum[C_MSB] != r_a[C_MSB]);
  // c1 and the pass-2 carry are mutually exclusive, so OR gives the carry
  // of the full A + ~B + 1.
  assign w_sub_c   = r_c1 | bus.add_cout;

`ifdef RESTADOR_SAT_EN
  assign w_add_res = bus.add_cout ? {WIDTH{1'b1}} : bus.add_sum;
  assign w_sub_res = w_sub_c      ? bus.add_sum   : '0;
`else
  assign w_add_res = bus.add_sum;
  assign w_sub_res = bus.add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_t     <= '0;
      r_c1    <= 1'b0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_op    <= bus.op;
            r_state <= S_PASS1;
          end
        end
        S_PASS1: begin
          r_t  <= bus.add_sum;
          r_c1 <= bus.add_cout;
          if (r_op) begin
            r_state <= S_PASS2;
          end else begin
            r_res   <= w_add_res;
            r_c     <= bus.add_cout;
            r_ovf   <= w_add_ovf;
            r_zero  <= (w_add_res == '0);
            r_state <= S_DONE;
          end
        end
        S_PASS2: begin
          r_res   <= w_sub_res;
          r_c     <= w_sub_c;
          r_ovf   <= w_sub_ovf;
          r_zero  <= (w_sub_res == '0);
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;
  assign bus.Res       = r_res;
  assign bus.C         = r_c;
  assign bus.Ovf       = r_ovf;
  assign bus.Zero      = r_zero;

endmodule

`default_nettype wire
